// File: rtl/tick_gen_prog.sv
// tick_gen_prog: programmable tick generator with periodic and one-shot modes,
// runtime divisor reload and a square-wave output that toggles on every tick.
module tick_gen_prog #(
  parameter int N_BIT       = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [N_BIT-1:0] div_in,
  input  logic             start,
  input  logic             mode,
  input  logic             stop,
  output logic             tick,
  output logic             sq,
  output logic [N_BIT-1:0] count,
  output logic [N_BIT-1:0] div_q,
  output logic             busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic mode_q, tick_q, sq_q;
  logic [N_BIT-1:0] count_q, div_eff;
  logic term;
  // a divisor of 0 is treated as 1 so the terminal count is always reachable
  always_comb begin
    div_eff = (div_q == '0) ? N_BIT'(1) : div_q;
    term    = count_q == div_eff - N_BIT'(1);
  end
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= RUN;
      mode_q  <= 1'b0;
      count_q <= '0;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      div_q   <= N_BIT'(DEFAULT_DIV);
    end else if (stop) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (load || start) begin
      if (load) div_q <= div_in;
      if (start) begin
        state_q <= RUN;
        mode_q  <= mode;
      end
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (state_q == RUN && enable) begin
      tick_q  <= term;
      sq_q    <= sq_q ^ term;
      count_q <= term ? '0 : count_q + N_BIT'(1);
      if (term && mode_q) state_q <= IDLE;
    end else begin
      tick_q <= 1'b0;
    end
  end
  assign tick  = tick_q;
  assign sq    = sq_q;
  assign count = count_q;
  assign busy  = state_q == RUN;
endmodule

// File: tb/tb_tick_gen_prog.sv
// tb_tick_gen_prog: scoreboard bench for tick_gen_prog (16-bit, D=5 default)
// plus an 8-bit build exercising the maximum divisor of 255.
module tb_tick_gen_prog;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, enable, load, start, mode, stop, tick, sq, busy;
  logic [15:0] div_in, count, div_q;
  logic rst8 = 1'b1, en8 = 1'b0, tick8, sq8, busy8;
  logic [7:0] count8, div8;
  typedef struct packed {
    logic b;
    logic s;
    logic t;
    logic [15:0] c;
    logic [15:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t e, o;
  int n_run = 0, n_fail = 0;
  logic exp_sq = 1'b0;

  tick_gen_prog #(.N_BIT(16), .DEFAULT_DIV(5)) u_dut (
    .clkin(clk), .rst(rst), .enable(enable), .load(load), .div_in(div_in),
    .start(start), .mode(mode), .stop(stop), .tick(tick), .sq(sq),
    .count(count), .div_q(div_q), .busy(busy)
  );

  tick_gen_prog #(.N_BIT(8), .DEFAULT_DIV(255)) u_dut8 (
    .clkin(clk), .rst(rst8), .enable(en8), .load(1'b0), .div_in(8'd0),
    .start(1'b0), .mode(1'b0), .stop(1'b0), .tick(tick8), .sq(sq8),
    .count(count8), .div_q(div8), .busy(busy8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic r, en, ld, input logic [15:0] di, input logic st, md, sp);
    rst = r; enable = en; load = ld; div_in = di; start = st; mode = md; stop = sp;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, t, input logic [15:0] c, d);
    if (t) exp_sq = ~exp_sq;
    sb.push_back('{b: b, s: exp_sq, t: t, c: c, d: d});
  endtask

  function automatic exp_t obs();
    return '{b: busy, s: sq, t: tick, c: count, d: div_q};
  endfunction

  function automatic string fs(input exp_t x);
    return $sformatf("busy=%b sq=%b tick=%b count=%0d div=%0d", x.b, x.s, x.t, x.c, x.d);
  endfunction

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    exp_sq = 1'b0;
    push(1, 0, 0, 5);
    cyc();
    e = sb.pop_front(); o = obs(); n_run++;
    if (o !== e) begin n_fail++; $display("FAIL reset: got %s want %s", fs(o), fs(e)); end
  endtask

  task automatic test_periodic();
    for (int k = 1; k <= 15; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      push(1, k % 5 == 0, 16'(k % 5), 5);
      cyc();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL periodic cyc%0d: got %s want %s", k, fs(o), fs(e)); end
    end
  endtask

  task automatic test_enable_toggle();
    int n = 0;
    drive(0, 0, 1, 4, 0, 0, 0);
    push(1, 0, 0, 4);
    cyc();
    e = sb.pop_front(); o = obs(); n_run++;
    if (o !== e) begin n_fail++; $display("FAIL en_toggle load: got %s want %s", fs(o), fs(e)); end
    for (int j = 0; j < 16; j++) begin
      logic en;
      en = (j % 2 == 0);
      if (en) n++;
      drive(0, en, 0, 0, 0, 0, 0);
      push(1, en && n % 4 == 0, 16'(n % 4), 4);
      cyc();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL en_toggle cyc%0d: got %s want %s", j, fs(o), fs(e)); end
    end
  endtask

  task automatic test_load();
    for (int k = 0; k < 54; k++) begin
      if (k == 0) begin
        drive(0, 0, 1, 100, 0, 0, 0); push(1, 0, 0, 100);
      end else if (k <= 40) begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, 0, 16'(k), 100);
      end else if (k == 41 || k == 50) begin
        drive(0, 1, 1, 3, 0, 0, 0); push(1, 0, 0, 3);
      end else if (k < 50) begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, (k - 41) % 3 == 0, 16'((k - 41) % 3), 3);
      end else begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, (k - 50) % 3 == 0, 16'((k - 50) % 3), 3);
      end
      cyc();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL load k%0d: got %s want %s", k, fs(o), fs(e)); end
    end
  endtask

  task automatic test_oneshot();
    drive(0, 0, 1, 6, 0, 0, 0);
    push(1, 0, 0, 6);
    cyc();
    e = sb.pop_front(); o = obs(); n_run++;
    if (o !== e) begin n_fail++; $display("FAIL oneshot load: got %s want %s", fs(o), fs(e)); end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k <= 10; k++) begin
        if (k == 0) begin
          drive(0, 1, 0, 0, 1, 1, 0); push(1, 0, 0, 6);
        end else begin
          drive(0, 1, 0, 0, 0, 0, 0);
          push(k < 6, k == 6, k < 6 ? 16'(k) : 16'd0, 6);
        end
        cyc();
        e = sb.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL oneshot r%0d k%0d: got %s want %s", r, k, fs(o), fs(e)); end
      end
    end
  endtask

  task automatic test_div_small();
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k <= 4; k++) begin
        if (k == 0) begin
          drive(0, 1, 1, 16'(v), 1, 0, 0); push(1, 0, 0, 16'(v));
        end else begin
          drive(0, 1, 0, 0, 0, 0, 0); push(1, 1, 0, 16'(v));
        end
        cyc();
        e = sb.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL div%0d k%0d: got %s want %s", v, k, fs(o), fs(e)); end
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 25; k++) begin
      if (k == 0) begin
        drive(0, 0, 1, 10, 1, 0, 0); push(1, 0, 0, 10);
      end else if (k <= 3) begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, 0, 16'(k), 10);
      end else if (k == 4) begin
        drive(0, 1, 0, 0, 1, 0, 1); push(0, 0, 0, 10);
      end else if (k <= 7) begin
        drive(0, 1, 0, 0, 0, 0, 0); push(0, 0, 0, 10);
      end else if (k == 8) begin
        drive(0, 1, 1, 4, 1, 0, 0); push(1, 0, 0, 4);
      end else if (k <= 12) begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, k == 12, 16'((k - 8) % 4), 4);
      end else if (k <= 15) begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, 0, 16'(k - 12), 4);
      end else if (k == 16) begin
        drive(1, 1, 0, 0, 0, 0, 0); exp_sq = 1'b0; push(1, 0, 0, 5);
      end else begin
        drive(0, 1, 0, 0, 0, 0, 0); push(1, (k - 16) % 5 == 0, 16'((k - 16) % 5), 5);
      end
      cyc();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL simult k%0d: got %s want %s", k, fs(o), fs(e)); end
    end
  endtask

  task automatic test_max();
    logic [7:0] peak = 8'd0;
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_sq = 1'b0;
    rst8 = 1'b0;
    en8 = 1'b1;
    for (int k = 1; k <= 510; k++) begin
      push(1, k % 255 == 0, 16'(k % 255), 255);
      cyc();
      if (count8 > peak) peak = count8;
      e = sb.pop_front();
      o = '{b: busy8, s: sq8, t: tick8, c: {8'h00, count8}, d: {8'h00, div8}};
      n_run++;
      if (o !== e) begin n_fail++; $display("FAIL max k%0d: got %s want %s", k, fs(o), fs(e)); end
    end
    n_run++;
    if (peak !== 8'd254) begin n_fail++; $display("FAIL max peak: got %0d want 254", peak); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_enable_toggle();
    test_load();
    test_oneshot();
    test_div_small();
    test_simultaneous();
    test_max();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tick_gen_prog.md
# tick_gen_prog

Programmable tick generator that replaces the fixed divide-by-50000 prescaler. It counts enabled cycles of `clkin` and emits a one-cycle `tick` every `div_q` enabled cycles. The divisor can be reloaded at runtime, and the block runs in either periodic or one-shot mode. It drives timebases for display multiplexing, debouncers and delay timers in the lab designs.

## Interface
Parameters:
- `N_BIT`, 16: width of the counter and the divisor.
- `DEFAULT_DIV`, 50000: reset value of the divisor register, i.e. the tick period in enabled cycles.

Ports:
- `clkin`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `enable`  in  1: count qualifier; the counter advances only on edges where `enable`=1.
- `load`  in  1: on this edge, copy `div_in` into `div_q`.
- `div_in`  in  N_BIT: new divisor value.
- `start`  in  1: (re)start counting from 0, latching `mode`.
- `mode`  in  1: sampled on `start`; 0 = periodic, 1 = one-shot.
- `stop`  in  1: halt and return to IDLE.
- `tick`  out  1: registered pulse, one cycle wide.
- `sq`  out  1: square wave that toggles on every tick.
- `count`  out  N_BIT: current count value.
- `div_q`  out  N_BIT: current divisor.
- `busy`  out  1: high when the state is RUN.

## Operation
- States are IDLE and RUN.
- On reset the block enters RUN with mode_q=0 (periodic), so it drops in for the old fixed divider.
- Reset values: `count`=0, `tick`=0, `sq`=0, `div_q`=DEFAULT_DIV, `busy`=1.
- Effective divisor D = max(`div_q`, 1). A `div_q` of 0 behaves exactly like 1.
- Priority per edge, highest first: `rst` > `stop` > (`load`, `start`) > counting.
- `stop`: forces IDLE, `count`<=0, `tick`<=0. Any `load` or `start` on the same edge is ignored.
- `load`: `div_q`<=`div_in`, `count`<=0, `tick`<=0. State is unchanged. It is legal in either state.
- `start`: RUN, mode_q<=`mode`, `count`<=0, `tick`<=0. It is legal in either state; in RUN it restarts the count. `load` and `start` on the same edge both take effect.
- Counting happens only in RUN, with `enable`=1 and none of the above asserted:
  - If `count` == D−1: `tick`<=1, `count`<=0, `sq`<=~`sq`. If mode_q=1, the state goes to IDLE on the same edge.
  - Otherwise: `count`<=`count`+1, `tick`<=0.
- With `enable`=0, or in IDLE: `count` holds and `tick`<=0. This deliberately differs from the old divider, which held `tick` while disabled.
- `count` never exceeds D−1 while counting. If `div_q` shrinks, the load also clears `count`, so the counter never wraps past the terminal value.
- `busy` is combinational from the state register.
- `sq` is not cleared by `stop`, `load` or `start`; only `rst` clears it.

## Timing
- Latency: after the edge that applies `start`, `load` or `rst`, `tick` is high in the cycle following the D-th enabled edge.
- `tick` period is D enabled cycles, exactly, with no +1 offset.
- `tick` is high for exactly one clock cycle, even when `enable` stays high.
- D=1: `tick` is high continuously while `enable`=1 in RUN periodic mode, `count` stays 0 and `sq` toggles every cycle.
- One-shot: `busy` falls in the same cycle that `tick` rises.
- A `load` arriving on the terminal edge suppresses that tick, because load wins.
- Mid-operation `rst` overrides everything on that edge and restores all reset values.

## Test plan
- Reset, then `enable`=1 held with DEFAULT_DIV overridden to 5:
  - `tick` high on cycles 5, 10, 15 after reset release.
  - `count` sequence 1,2,3,4,0.
  - `sq` = 1, 0, 1 after successive ticks.
- `enable` toggling 1/0 every cycle with D=4: tick interval is 8 clocks, `count` holds on disabled cycles, and `tick` never lasts 2 cycles.
- `load` with `div_in`=3 mid-count at `count`=40 (D=100):
  - `count` goes to 0 and `div_q`=3.
  - Next ticks come 3 enabled cycles apart.
  - A load on the terminal edge produces no tick that cycle.
- One-shot: `start`=1, `mode`=1, D=6:
  - `busy`=1 for 6 enabled cycles, then a single tick with `busy`=0 in the same cycle.
  - No further ticks with `enable` held.
  - A re-`start` yields one more tick.
- `div_in`=0 and `div_in`=1: a tick every enabled cycle and `count` stays 0. Maximum value 2^N_BIT−1 (N_BIT=8 build, 255): tick every 255 cycles, `count` peaks at 254 and never wraps.
- Simultaneous events:
  - `stop`+`start`: ends in IDLE with `count`=0.
  - `load`+`start`: new divisor and restart on the same edge.
  - `rst` asserted mid-count at `count`=3: next cycle `count`=0, `tick`=0, `sq`=0, `div_q`=DEFAULT_DIV, `busy`=1.
